// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Single-entry issue controller between the instruction decoder and the
// execute pipes. One decoded instruction is buffered. A 32-bit pending
// scoreboard records outstanding register writes. The buffered instruction is
// dispatched with a wrapping sequence tag once:
//   - its RAW and WAW hazards have cleared, and
//   - its target pipe is ready.
// After a control-flow instruction issues, all issue stops until br_resolve.
//
// Handshake semantics (both D_* and X_* sides):
//   - A transfer happens on a rising clk edge where valid and ready are both 1.
//   - A valid source holds its fields stable until the transfer.
//   - X_val never depends on X_rdy.
//   - D_rdy is combinational from state, the scoreboard and X_rdy.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   D_val / D_rdy         decoder handshake
//   D_uop, D_jal          micro-op (3-bit encoding below); jal kind (0 none, 1 jal, 2 jalr)
//   D_raddr0/1, D_waddr   source and destination registers
//   D_wen                 instruction writes D_waddr
//   X_val / X_rdy         one-hot dispatch valid / per-pipe ready ([0] ALU, [1] MUL, [2] MEM)
//   X_uop..X_wen          buffered instruction fields
//   X_seq                 sequence tag of the dispatched instruction
//   C_val, C_waddr        writeback completion clears a pending bit
//   br_resolve            the outstanding control instruction has resolved
//   busy                  anything buffered, waiting or pending
//   dbg_state             FSM state (0 EMPTY, 1 HELD, 2 BR_WAIT)
//   dbg_pending           scoreboard bits
//
// uop encoding:
//   0 ADD, 1 MUL, 2 LW, 3 SW, 4 JAL, 5 JALR, 6 BNE
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int SEQ_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                D_val,
  output logic                D_rdy,
  input  logic [2:0]          D_uop,
  input  logic [1:0]          D_jal,
  input  logic [4:0]          D_raddr0,
  input  logic [4:0]          D_raddr1,
  input  logic [4:0]          D_waddr,
  input  logic                D_wen,
  output logic [2:0]          X_val,
  input  logic [2:0]          X_rdy,
  output logic [2:0]          X_uop,
  output logic [4:0]          X_raddr0,
  output logic [4:0]          X_raddr1,
  output logic [4:0]          X_waddr,
  output logic                X_wen,
  output logic [SEQ_BITS-1:0] X_seq,
  input  logic                C_val,
  input  logic [4:0]          C_waddr,
  input  logic                br_resolve,
  output logic                busy,
  output logic [1:0]          dbg_state,
  output logic [31:0]         dbg_pending
);

  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_BNE = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HELD    = 2'd1,
    ST_BR_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_uop;
  logic [1:0]          r_jal;
  logic [4:0]          r_raddr0;
  logic [4:0]          r_raddr1;
  logic [4:0]          r_waddr;
  logic                r_wen;
  logic [31:0]         r_pending;
  logic [31:0]         w_pending_nxt;
  logic [SEQ_BITS-1:0] r_seq;

  logic       w_ctrl;
  logic       w_hazard;
  logic [2:0] w_pipe;
  logic       w_issue;
  logic       w_load;

  // Route the buffered uop to its pipe.
  always_comb begin
    w_pipe = 3'b001;
    if (r_uop == OP_MUL) begin
      w_pipe = 3'b010;
    end else if (r_uop == OP_LW || r_uop == OP_SW) begin
      w_pipe = 3'b100;
    end
  end

  assign w_ctrl = (r_jal != 2'd0) || (r_uop == OP_BNE);

  // Only registered scoreboard bits are used, so a completion unblocks a
  // dependent instruction one cycle after its edge. pending[0] is never set,
  // so x0 sources and destinations never create a hazard.
  assign w_hazard = r_pending[r_raddr0] | r_pending[r_raddr1] |
                    (r_wen & r_pending[r_waddr]);

  assign X_val   = (r_state == ST_HELD && !w_hazard) ? w_pipe : 3'b000;
  assign w_issue = |(X_val & X_rdy);

  // A control instruction leaves the buffer without admitting a successor,
  // because nothing may follow it until it resolves.
  assign D_rdy  = (r_state == ST_EMPTY) || (w_issue && !w_ctrl);
  assign w_load = D_val && D_rdy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (D_val) w_state_nxt = ST_HELD;
      end
      ST_HELD: begin
        if (w_issue) begin
          if (w_ctrl)     w_state_nxt = ST_BR_WAIT;
          else if (D_val) w_state_nxt = ST_HELD;
          else            w_state_nxt = ST_EMPTY;
        end
      end
      ST_BR_WAIT: begin
        if (br_resolve) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Set and clear never collide: a pending destination blocks issue via WAW.
  always_comb begin
    w_pending_nxt = r_pending;
    if (C_val) w_pending_nxt[C_waddr] = 1'b0;
    if (w_issue && r_wen && r_waddr != 5'd0) w_pending_nxt[r_waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_pending <= '0;
      r_seq     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (w_issue) r_seq <= r_seq + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uop    <= '0;
      r_jal    <= '0;
      r_raddr0 <= '0;
      r_raddr1 <= '0;
      r_waddr  <= '0;
      r_wen    <= 1'b0;
    end else if (w_load) begin
      r_uop    <= D_uop;
      r_jal    <= D_jal;
      r_raddr0 <= D_raddr0;
      r_raddr1 <= D_raddr1;
      r_waddr  <= D_waddr;
      r_wen    <= D_wen;
    end
  end

  assign X_uop       = r_uop;
  assign X_raddr0    = r_raddr0;
  assign X_raddr1    = r_raddr1;
  assign X_waddr     = r_waddr;
  assign X_wen       = r_wen;
  assign X_seq       = r_seq;
  assign busy        = (r_state != ST_EMPTY) || (|r_pending);
  assign dbg_state   = r_state;
  assign dbg_pending = r_pending;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_BNE  = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       D_val, D_rdy, D_wen, X_wen, C_val, br_resolve, busy;
  logic [2:0] D_uop, X_val, X_rdy, X_uop;
  logic [1:0] D_jal, dbg_state;
  logic [4:0] D_raddr0, D_raddr1, D_waddr, X_raddr0, X_raddr1, X_waddr, C_waddr;
  logic [3:0] X_seq;
  logic [31:0] dbg_pending;

  issue_scoreboard #(.SEQ_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_val(D_val), .D_rdy(D_rdy), .D_uop(D_uop), .D_jal(D_jal),
    .D_raddr0(D_raddr0), .D_raddr1(D_raddr1), .D_waddr(D_waddr), .D_wen(D_wen),
    .X_val(X_val), .X_rdy(X_rdy), .X_uop(X_uop), .X_raddr0(X_raddr0),
    .X_raddr1(X_raddr1), .X_waddr(X_waddr), .X_wen(X_wen), .X_seq(X_seq),
    .C_val(C_val), .C_waddr(C_waddr), .br_resolve(br_resolve), .busy(busy),
    .dbg_state(dbg_state), .dbg_pending(dbg_pending)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [25:0] exp_q[$];
  logic [3:0]  tb_seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pipe_of(input logic [2:0] uop);
    if (uop == OP_MUL) return 3'b010;
    if (uop == OP_LW || uop == OP_SW) return 3'b100;
    return 3'b001;
  endfunction

  // Every driven instruction is expected to issue in order with the next tag.
  task automatic drive(input logic [2:0] uop, input logic [1:0] jal, input logic [4:0] ra0,
                       input logic [4:0] ra1, input logic [4:0] wa, input logic wen);
    D_val = 1'b1; D_uop = uop; D_jal = jal;
    D_raddr0 = ra0; D_raddr1 = ra1; D_waddr = wa; D_wen = wen;
    exp_q.push_back({pipe_of(uop), uop, wa, wen, ra0, ra1, tb_seq});
    tb_seq = tb_seq + 4'd1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic complete(input logic [4:0] r);
    C_val = 1'b1; C_waddr = r;
    step();
    C_val = 1'b0;
  endtask

  // Issue monitor: compares each dispatched instruction with the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("onehot", 32'($countones(X_val) <= 1), 32'd1);
      if ((X_val & X_rdy) != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", {29'd0, X_val}, 32'd0);
        end else begin
          chk("issue", {6'd0, X_val, X_uop, X_waddr, X_wen, X_raddr0, X_raddr1, X_seq},
              {6'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1; D_val = 0; D_uop = 0; D_jal = 0; D_raddr0 = 0; D_raddr1 = 0;
    D_waddr = 0; D_wen = 0; X_rdy = 3'b111; C_val = 0; C_waddr = 0; br_resolve = 0;
    tb_seq = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_xval", {29'd0, X_val}, 32'd0);
    chk("rst_drdy", {31'd0, D_rdy}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_seq", {28'd0, X_seq}, 32'd0);
    chk("rst_fields", {16'd0, X_uop, X_waddr, X_raddr0, X_wen}, 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Back-to-back ADDs
    drive(OP_ADD, 2'd0, 5'd0, 5'd0, 5'd1, 1'b1);
    step();
    drive(OP_ADD, 2'd0, 5'd0, 5'd0, 5'd2, 1'b1);
    @(negedge clk);
    chk("b2b_xval0", {29'd0, X_val}, 32'd1);
    chk("b2b_seq0", {28'd0, X_seq}, 32'd0);
    chk("b2b_drdy", {31'd0, D_rdy}, 32'd1);
    step();
    drive(OP_ADD, 2'd0, 5'd0, 5'd0, 5'd3, 1'b1);
    @(negedge clk);
    chk("b2b_xval1", {29'd0, X_val}, 32'd1);
    chk("b2b_seq1", {28'd0, X_seq}, 32'd1);
    step();
    D_val = 1'b0;
    @(negedge clk);
    chk("b2b_xval2", {29'd0, X_val}, 32'd1);
    chk("b2b_seq2", {28'd0, X_seq}, 32'd2);
    step();
    @(negedge clk);
    chk("b2b_idle", {29'd0, X_val}, 32'd0);
    chk("b2b_pending", dbg_pending, 32'h0000_000E);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    complete(5'd1); complete(5'd2); complete(5'd3);
    chk("b2b_drained", dbg_pending, 32'd0);

    // RAW stall
    drive(OP_ADD, 2'd0, 5'd0, 5'd0, 5'd5, 1'b1);
    step();
    drive(OP_ADD, 2'd0, 5'd5, 5'd0, 5'd6, 1'b1);
    @(negedge clk);
    chk("raw_first", {29'd0, X_val}, 32'd1);
    step();
    D_val = 1'b0;
    @(negedge clk);
    chk("raw_stall0", {29'd0, X_val}, 32'd0);
    chk("raw_pend5", dbg_pending, 32'h0000_0020);
    step();
    @(negedge clk);
    chk("raw_stall1", {29'd0, X_val}, 32'd0);
    C_val = 1'b1; C_waddr = 5'd5;
    #1;
    chk("raw_no_bypass", {29'd0, X_val}, 32'd0);
    step();
    C_val = 1'b0;
    @(negedge clk);
    chk("raw_release", {29'd0, X_val}, 32'd1);
    step();
    @(negedge clk);
    chk("raw_done", {29'd0, X_val}, 32'd0);
    chk("raw_pend6", dbg_pending, 32'h0000_0040);
    complete(5'd6);

    // Pipe routing and backpressure; br_resolve while HELD is ignored
    X_rdy = 3'b101;
    drive(OP_MUL, 2'd0, 5'd1, 5'd2, 5'd7, 1'b1);
    step();
    drive(OP_SW, 2'd0, 5'd3, 5'd4, 5'd0, 1'b0);
    @(negedge clk);
    chk("bp_xval0", {29'd0, X_val}, 32'b010);
    chk("bp_drdy0", {31'd0, D_rdy}, 32'd0);
    chk("bp_uop0", {29'd0, X_uop}, {29'd0, OP_MUL});
    br_resolve = 1'b1;
    step();
    br_resolve = 1'b0;
    @(negedge clk);
    chk("bp_xval1", {29'd0, X_val}, 32'b010);
    chk("bp_state", {30'd0, dbg_state}, 32'd1);
    chk("bp_waddr", {27'd0, X_waddr}, 32'd7);
    chk("bp_drdy1", {31'd0, D_rdy}, 32'd0);
    step();
    @(negedge clk);
    chk("bp_xval2", {29'd0, X_val}, 32'b010);
    chk("bp_raddr", {22'd0, X_raddr0, X_raddr1}, {22'd0, 5'd1, 5'd2});
    X_rdy = 3'b111;
    #1;
    chk("bp_drdy_rise", {31'd0, D_rdy}, 32'd1);
    step();
    D_val = 1'b0;
    @(negedge clk);
    chk("bp_sw_xval", {29'd0, X_val}, 32'b100);
    step();
    @(negedge clk);
    chk("bp_idle", {29'd0, X_val}, 32'd0);
    chk("bp_pend7", dbg_pending, 32'h0000_0080);
    complete(5'd7);

    // Branch blocking
    drive(OP_BNE, 2'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    step();
    drive(OP_ADD, 2'd0, 5'd0, 5'd0, 5'd9, 1'b1);
    @(negedge clk);
    chk("br_xval", {29'd0, X_val}, 32'd1);
    chk("br_drdy_issue", {31'd0, D_rdy}, 32'd0);
    step();
    @(negedge clk);
    chk("br_wait_state", {30'd0, dbg_state}, 32'd2);
    chk("br_wait_drdy0", {31'd0, D_rdy}, 32'd0);
    chk("br_wait_xval", {29'd0, X_val}, 32'd0);
    step();
    @(negedge clk);
    chk("br_wait_drdy1", {31'd0, D_rdy}, 32'd0);
    br_resolve = 1'b1;
    step();
    br_resolve = 1'b0;
    @(negedge clk);
    chk("br_after_drdy", {31'd0, D_rdy}, 32'd1);
    chk("br_after_xval", {29'd0, X_val}, 32'd0);
    step();
    D_val = 1'b0;
    @(negedge clk);
    chk("br_add_xval", {29'd0, X_val}, 32'd1);
    step();
    @(negedge clk);
    chk("br_add_done", {29'd0, X_val}, 32'd0);
    chk("br_pend9", dbg_pending, 32'h0000_0200);

    // JALR with link write; a completion lands during BR_WAIT
    drive(OP_JALR, 2'd2, 5'd1, 5'd0, 5'd10, 1'b1);
    step();
    D_val = 1'b0;
    @(negedge clk);
    chk("jalr_drdy", {31'd0, D_rdy}, 32'd0);
    step();
    C_val = 1'b1; C_waddr = 5'd9;
    @(negedge clk);
    chk("jalr_state", {30'd0, dbg_state}, 32'd2);
    step();
    C_val = 1'b0;
    @(negedge clk);
    chk("jalr_cval_in_wait", dbg_pending, 32'h0000_0400);
    br_resolve = 1'b1;
    step();
    br_resolve = 1'b0;
    @(negedge clk);
    chk("jalr_resolved", {30'd0, dbg_state}, 32'd0);
    chk("jalr_busy", {31'd0, busy}, 32'd1);
    complete(5'd10);
    @(negedge clk);
    chk("jalr_idle_busy", {31'd0, busy}, 32'd0);

    // Mid-operation reset with 3 pending registers and a held instruction
    step();
    drive(OP_ADD, 2'd0, 5'd0, 5'd0, 5'd11, 1'b1);
    step();
    drive(OP_ADD, 2'd0, 5'd0, 5'd0, 5'd12, 1'b1);
    step();
    drive(OP_ADD, 2'd0, 5'd0, 5'd0, 5'd13, 1'b1);
    step();
    drive(OP_MUL, 2'd0, 5'd11, 5'd0, 5'd14, 1'b1);
    step();
    D_val = 1'b0;
    @(negedge clk);
    chk("rst_pre_pending", dbg_pending, 32'h0000_3800);
    chk("rst_pre_state", {30'd0, dbg_state}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_xval", {29'd0, X_val}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_drdy", {31'd0, D_rdy}, 32'd1);
    exp_q.delete();
    tb_seq = 4'd0;
    step();
    rst_n = 1'b1;
    C_val = 1'b1; C_waddr = 5'd11;
    step();
    C_val = 1'b0;
    @(negedge clk);
    chk("post_rst_pending", dbg_pending, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // 17 ADDs to x0: no pending bits, tag wraps
    for (int i = 0; i < 17; i++) begin
      drive(OP_ADD, 2'd0, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'd0, 1'b1);
      step();
      @(negedge clk);
      chk("x0_xval", {29'd0, X_val}, 32'd1);
      chk("x0_seq", {28'd0, X_seq}, {28'd0, 4'(i)});
      chk("x0_pending", dbg_pending, 32'd0);
    end
    D_val = 1'b0;
    step();
    @(negedge clk);
    chk("x0_idle", {29'd0, X_val}, 32'd0);
    chk("x0_busy", {31'd0, busy}, 32'd0);
    chk("x0_seq_after", {28'd0, X_seq}, 32'd1);
    chk("drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Single-entry issue controller between `InstDecoder` and the execute pipes. It buffers one decoded instruction and tracks outstanding register writes in a 32-entry scoreboard. It holds the instruction until its RAW/WAW hazards clear and its target pipe is ready, then dispatches it with a sequence tag. After a control-flow instruction issues, it stops all issue until that instruction resolves.

## Interface
- `SEQ_BITS`, 4, width of the wrapping issue sequence tag
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `D_val`  in  1  decoded instruction valid
- `D_rdy`  out  1  controller accepts the instruction this cycle
- `D_uop`  in  rv_uop  micro-op from decoder
- `D_jal`  in  2  0 = none, 1 = jal, 2 = jalr
- `D_raddr0`, `D_raddr1`  in  5 each  source registers; 0 means no dependency
- `D_waddr`  in  5  destination register
- `D_wen`  in  1  instruction writes `D_waddr`
- `X_val`  out  3  one-hot dispatch valid: [0] ALU, [1] MUL, [2] MEM
- `X_rdy`  in  3  per-pipe ready
- `X_uop`, `X_raddr0`, `X_raddr1`, `X_waddr`, `X_wen`  out  as D_*  buffered instruction fields
- `X_seq`  out  SEQ_BITS  sequence tag of the dispatched instruction
- `C_val`  in  1  writeback completion
- `C_waddr`  in  5  register whose write has completed
- `br_resolve`  in  1  the outstanding control instruction has resolved
- `busy`  out  1  state != EMPTY or any scoreboard bit set

## Operation
- States:
  - EMPTY: no instruction buffered.
  - HELD: one instruction buffered.
  - BR_WAIT: a control instruction has issued; waiting for `br_resolve`.
- Pipe mapping:
  - OP_MUL goes to pipe 1.
  - OP_LW and OP_SW go to pipe 2.
  - All other uops (ADD, JAL, JALR, BNE) go to pipe 0.
- Control instruction: `D_jal != 0` or uop == OP_BNE.
- Hazard check uses registered scoreboard bits only; there is no completion bypass.
  - RAW: `pending[raddr0]` or `pending[raddr1]`.
  - WAW: `wen && pending[waddr]`.
  - Register x0 is never pending.
- `issue` = HELD && no hazard && `X_rdy[pipe]`.
- `X_val[pipe]` = HELD && no hazard. `X_val` is independent of `X_rdy`, and at most one bit is set.
- `D_rdy` = EMPTY, or (`issue` && buffered instruction is not control).
- Transitions:
  - EMPTY to HELD on `D_val`.
  - HELD with `issue` and a control instruction goes to BR_WAIT.
  - HELD with `issue` and a non-control instruction goes to HELD if `D_val`, otherwise EMPTY.
  - BR_WAIT to EMPTY on `br_resolve`.
  - In BR_WAIT, `D_rdy` = 0.
- Scoreboard update each cycle:
  - Set `pending[X_waddr]` on `issue && X_wen && X_waddr != 0`.
  - Clear `pending[C_waddr]` on `C_val`.
  - Set and clear can never target the same register in one cycle, because WAW blocks issue.
  - `C_val` for a register that is not pending has no effect.
- `seq` increments by 1 on each `issue` and wraps from 2^SEQ_BITS−1 to 0. `X_seq` = current `seq`.
- `br_resolve` outside BR_WAIT is ignored.
- `C_val` is honoured in every state, including BR_WAIT.

## Timing
- Reset values:
  - state = EMPTY; pending = 0; seq = 0.
  - `X_val` = 0; `D_rdy` = 1; `busy` = 0.
  - X_* field outputs are 0.
- An asserted `rst_n` low discards the buffered instruction and all pending bits immediately, regardless of clock.
- Minimum latency:
  - An instruction accepted at edge N presents `X_val` in cycle N+1 and issues at edge N+1.
  - Back-to-back non-dependent, non-control instructions sustain 1 issue per cycle.
- Completion penalty: a `C_val` at edge N unblocks a dependent instruction in cycle N+1, not in cycle N.
- Control-flow penalty: the first post-branch instruction can be accepted in the cycle after `br_resolve` is sampled.
- Handshakes:
  - X_* fields hold stable while `X_val` is high and the matching `X_rdy` is low.
  - `D_rdy` is combinational from state, scoreboard and `X_rdy`.

## Test plan
- **Back-to-back ADDs.** Stream ADD x1, ADD x2, ADD x3 with all `X_rdy` = 1 and no dependencies. Required: `X_val` = 3'b001 on 3 consecutive cycles, `X_seq` = 0, 1, 2, `pending` = {x1, x2, x3}.
- **RAW stall.** ADD x5 then ADDI x6 ← x5. Required: the second instruction stalls with `X_val` = 0 until `C_val`/`C_waddr` = 5, then issues exactly one cycle after the completion edge.
- **Pipe routing and backpressure.** Send MUL then SW with `X_rdy[1]` = 0 for 3 cycles. Required: `X_val` = 3'b010 is held with stable fields and `D_rdy` = 0; the MUL issues when `X_rdy[1]` rises; the SW then issues with `X_val` = 3'b100.
- **Branch blocking.** BNE followed by ADD on the input. Required: after the BNE issues, `D_rdy` = 0 until `br_resolve`, and the ADD issues two cycles after the resolve edge.
- **x0 and wrap.** Issue 17 ADDs writing x0 with SEQ_BITS = 4. Required: `pending` stays 0 and the 17th `X_seq` = 0.
- **Mid-operation reset.** Assert `rst_n` low asynchronously while HELD with 3 pending registers. Required: `X_val` = 0, `busy` = 0 and `D_rdy` = 1 before the next clock edge; a later `C_val` has no effect.
